// File: rtl/usb_pio_pkg.sv
// Shared register map and pulse-timer state encoding for the USB output PIO.
package usb_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/usb_pio_pulse_timer.sv
// One-shot pulse timer: latches a bit mask and holds it for len clocks.
// mask_nxt is the mask the outputs should carry after this clock edge.
module usb_pio_pulse_timer
  import usb_pio_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mask,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic [WIDTH-1:0] mask_nxt,
  output logic [LEN_W-1:0] cnt
);

  pulse_state_t     state_q, state_d;
  logic [WIDTH-1:0] mask_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    state_d  = state_q;
    mask_nxt = mask_q;
    cnt_d    = cnt;
    case (state_q)
      ST_IDLE: begin
        // Empty mask or zero length would be an invisible pulse; drop it.
        if (start && (mask != '0) && (len != '0)) begin
          state_d  = ST_ACTIVE;
          mask_nxt = mask;
          cnt_d    = len;
        end
      end
      ST_ACTIVE: begin
        if (cnt == LEN_W'(1)) begin
          state_d  = ST_IDLE;
          mask_nxt = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_nxt;
      cnt     <= cnt_d;
      busy    <= (state_d == ST_ACTIVE);
    end
  end

endmodule

// File: rtl/synthesizer_soc_usb_out_pio.sv
// Avalon-MM output PIO driving USB controller control lines; 1-clk read latency, no waitrequest.
// Optional timed-inversion pulse engine enabled by defining USB_OUT_PIO_PULSE_EN.
module synthesizer_soc_usb_out_pio
  import usb_pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] mask_nxt;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_nxt = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_nxt = wd;
        ADDR_OUTSET:   data_nxt = data_q | wd;
        ADDR_OUTCLEAR: data_nxt = data_q & ~wd;
        default:       data_nxt = data_q;
      endcase
    end
  end

`ifdef USB_OUT_PIO_PULSE_EN
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else if (wr_en && (address == ADDR_PULSE_LEN)) begin
      len_q <= writedata[LEN_W-1:0];
    end
  end

  usb_pio_pulse_timer #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_pulse_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (wr_en && (address == ADDR_PULSE)),
    .mask     (wd),
    .len      (len_q),
    .busy     (busy),
    .mask_nxt (mask_nxt),
    .cnt      (cnt)
  );

  assign pulse_busy = busy;
`else
  assign mask_nxt   = '0;
  assign pulse_busy = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: rd_mux[WIDTH-1:0] = data_q;
`ifdef USB_OUT_PIO_PULSE_EN
      ADDR_PULSE_LEN: rd_mux[LEN_W-1:0] = len_q;
      ADDR_PULSE: begin
        rd_mux[LEN_W-1:0] = cnt;
        rd_mux[31]        = busy;
      end
`endif
      default: rd_mux = '0;
    endcase
  end

  // out_port follows the next-state mask so the inversion tracks pulse_busy cycle for cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      out_port <= RESET_VALUE;
      readdata <= '0;
    end else begin
      data_q   <= data_nxt;
      out_port <= data_nxt ^ mask_nxt;
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_synthesizer_soc_usb_out_pio.sv
// Randomized self-checking bench for the USB output PIO against a cycle-level behavioural model.
module tb_synthesizer_soc_usb_out_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        pulse_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: data, pulse length, active mask and clocks of inversion remaining.
  logic [3:0]  m_data;
  logic [15:0] m_len;
  logic [3:0]  m_mask;
  int          m_left;
  logic [31:0] exp_rd;

  synthesizer_soc_usb_out_pio #(
    .WIDTH       (4),
    .RESET_VALUE (4'h5),
    .LEN_W       (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = 4'h5; m_len = '0; m_mask = '0; m_left = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0, 3'd4, 3'd5: r[3:0] = m_data;
`ifdef USB_OUT_PIO_PULSE_EN
      3'd2: r[15:0] = m_len;
      3'd3: begin r[15:0] = m_left[15:0]; r[31] = (m_left != 0); end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step(input logic w, input logic [2:0] a, input logic [31:0] d);
`ifdef USB_OUT_PIO_PULSE_EN
    if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mask = '0;
    end else if (w && a == 3'd3 && d[3:0] != 4'h0 && m_len != 0) begin
      m_left = int'(m_len);
      m_mask = d[3:0];
    end
    if (w && a == 3'd2) m_len = d[15:0];
`endif
    if (w) begin
      case (a)
        3'd0: m_data = d[3:0];
        3'd4: m_data = m_data | d[3:0];
        3'd5: m_data = m_data & ~d[3:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle; non-write cycles randomly mix chipselect/write_n to exercise strobe qualification.
  task automatic cyc(input logic w, input logic [2:0] a, input logic [31:0] d);
    int sel;
    @(negedge clk);
    if (w) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else begin
      sel = $urandom_range(0, 2);
      chipselect = (sel == 1);
      write_n    = (sel != 0);
    end
    address = a; writedata = d;
    exp_rd = model_read(a);
    @(posedge clk);
    model_step(w, a, d);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_port !== 4'h5) $display("FAIL reset_out_port got %h want 5", out_port); else n_pass++;
    n_checks++;
    if (pulse_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", pulse_busy); else n_pass++;
    n_checks++;
    if (readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", readdata); else n_pass++;
    cyc(1'b0, 3'd0, 32'h0);
    n_checks++;
    if (readdata !== 32'h5) $display("FAIL reset_read_data got %h want 5", readdata); else n_pass++;
  endtask

  task automatic test_set_clear();
    logic [3:0] want [2];
    want[0] = 4'h7; want[1] = 4'h6;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, (i == 0) ? 3'd4 : 3'd5, (i == 0) ? 32'h3 : 32'h1);
      n_checks++;
      if (out_port !== want[i] || out_port !== (m_data ^ m_mask))
        $display("FAIL set_clear_%0d got %h want %h", i, out_port, want[i]);
      else n_pass++;
    end
    cyc(1'b0, 3'd5, 32'h0);
    n_checks++;
    if (readdata !== 32'h6) $display("FAIL outclear_readback got %h want 6", readdata); else n_pass++;
  endtask

`ifdef USB_OUT_PIO_PULSE_EN
  task automatic test_pulse();
    int busy_cycles = 0;
    cyc(1'b1, 3'd2, 32'h3);
    cyc(1'b1, 3'd3, 32'h8);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_port !== ((k < 3) ? 4'hE : 4'h6) || out_port !== (m_data ^ m_mask))
        $display("FAIL pulse_out_%0d got %h want %h", k, out_port, (k < 3) ? 4'hE : 4'h6);
      else n_pass++;
      if (pulse_busy === 1'b1) busy_cycles++;
      cyc(1'b0, 3'd3, 32'h0);
    end
    n_checks++;
    if (busy_cycles != 3) $display("FAIL pulse_busy_len got %0d want 3", busy_cycles); else n_pass++;
  endtask

  task automatic test_pulse_ignored();
    cyc(1'b1, 3'd3, 32'h0);
    n_checks++;
    if (out_port !== 4'h6 || pulse_busy !== 1'b0)
      $display("FAIL zero_mask got out=%h busy=%b want 6/0", out_port, pulse_busy);
    else n_pass++;
    cyc(1'b1, 3'd2, 32'h0);
    cyc(1'b1, 3'd3, 32'h8);
    n_checks++;
    if (out_port !== 4'h6 || pulse_busy !== 1'b0)
      $display("FAIL zero_len got out=%h busy=%b want 6/0", out_port, pulse_busy);
    else n_pass++;
  endtask

  task automatic test_mid_pulse();
    logic [3:0] want [4];
    want[0] = 4'hE; want[1] = 4'hE; want[2] = 4'h8; want[3] = 4'h0;
    cyc(1'b1, 3'd2, 32'h3);
    cyc(1'b1, 3'd3, 32'h8);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_port !== want[k] || pulse_busy !== (k < 3))
        $display("FAIL mid_pulse_%0d got out=%h busy=%b want %h/%b", k, out_port, pulse_busy, want[k], k < 3);
      else n_pass++;
      if (k == 0) cyc(1'b1, 3'd3, 32'h1);
      else if (k == 1) cyc(1'b1, 3'd0, 32'h0);
      else if (k == 2) cyc(1'b0, 3'd3, 32'h0);
    end
  endtask

  task automatic test_reset_mid_pulse();
    cyc(1'b1, 3'd4, 32'h2);
    cyc(1'b1, 3'd3, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== 4'h5 || pulse_busy !== 1'b0 || readdata !== 32'h0)
      $display("FAIL reset_mid_pulse got out=%h busy=%b rd=%h want 5/0/0", out_port, pulse_busy, readdata);
    else n_pass++;
    model_reset();
    @(negedge clk) reset_n = 1'b1;
  endtask
`else
  task automatic test_disabled();
    cyc(1'b1, 3'd2, 32'h3);
    cyc(1'b1, 3'd3, 32'h8);
    n_checks++;
    if (out_port !== (m_data ^ m_mask) || pulse_busy !== 1'b0)
      $display("FAIL disabled_pulse got out=%h busy=%b want %h/0", out_port, pulse_busy, m_data);
    else n_pass++;
    cyc(1'b0, 3'd2, 32'h0);
    n_checks++;
    if (readdata !== 32'h0) $display("FAIL disabled_len_read got %h want 0", readdata); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    logic        w;
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = $urandom_range(0, 6);
      cyc(w, a, d);
      n_checks++;
      if (out_port !== (m_data ^ m_mask) || pulse_busy !== (m_left != 0) || readdata !== exp_rd)
        $display("FAIL random_%0d got out=%h busy=%b rd=%h want %h/%b/%h",
                 i, out_port, pulse_busy, readdata, m_data ^ m_mask, m_left != 0, exp_rd);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    #23;
    @(negedge clk) reset_n = 1'b1;
    #1;
    test_reset();
    test_set_clear();
`ifdef USB_OUT_PIO_PULSE_EN
    test_pulse();
    test_pulse_ignored();
    test_mid_pulse();
    test_reset_mid_pulse();
`else
    test_disabled();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
